// File: rtl/surf_axil_pkg.sv
// surf_axil_pkg: register map indices, bit positions and AXI response codes for surf_axil_ctrl
package surf_axil_pkg;
   localparam int REG_CTRL = 0;
   localparam int REG_STATUS = 1;
   localparam int REG_PARAM0 = 2;
   localparam int CTRL_START = 0;
   localparam int CTRL_IRQ_EN = 1;
   localparam int ST_READY = 0;
   localparam int ST_DONE = 1;
   localparam int ST_START_ERR = 2;
   localparam logic [1:0] RESP_OKAY = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
endpackage

// File: rtl/surf_axil_ctrl_if.sv
// surf_axil_ctrl_if: AXI4-Lite bus bundle between the PS master and the SURF register bank
//   DW: data width (32/64), AW: byte address width
//   master modport drives AW/W/AR payload+valid and B/R ready; slave modport is the reverse
interface surf_axil_ctrl_if #(
   parameter int DW = 32,
   parameter int AW = 7
);
   logic [AW-1:0]   awaddr;
   logic [2:0]      awprot;
   logic            awvalid;
   logic            awready;
   logic [DW-1:0]   wdata;
   logic [DW/8-1:0] wstrb;
   logic            wvalid;
   logic            wready;
   logic [1:0]      bresp;
   logic            bvalid;
   logic            bready;
   logic [AW-1:0]   araddr;
   logic [2:0]      arprot;
   logic            arvalid;
   logic            arready;
   logic [DW-1:0]   rdata;
   logic [1:0]      rresp;
   logic            rvalid;
   logic            rready;
   modport master (
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
             araddr, arprot, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
   modport slave (
      input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
             araddr, arprot, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/surf_axil_ctrl.sv
// surf_axil_ctrl: AXI4-Lite slave register bank controlling the SURF core
//   clk, rst (sync, active-low)
//   s00_axi      : AXI4-Lite slave port (surf_axil_ctrl_if.slave)
//   core_ready_i : core idle, may accept start
//   core_done_i  : one-cycle end-of-processing pulse
//   start_o      : one-cycle start pulse
//   params_o     : PARAM[i] at bits [i*DW +: DW]
//   irq_o        : registered done AND irq_en
module surf_axil_ctrl
   import surf_axil_pkg::*;
#(
   parameter int C_S00_AXI_DATA_WIDTH = 32,
   parameter int C_S00_AXI_ADDR_WIDTH = 7,
   parameter int NUM_PARAMS = 8
) (
   input  logic                                       clk,
   input  logic                                       rst,
   surf_axil_ctrl_if.slave                            s00_axi,
   input  logic                                       core_ready_i,
   input  logic                                       core_done_i,
   output logic                                       start_o,
   output logic [NUM_PARAMS*C_S00_AXI_DATA_WIDTH-1:0] params_o,
   output logic                                       irq_o
);
   localparam int DW = C_S00_AXI_DATA_WIDTH;
   localparam int AW = C_S00_AXI_ADDR_WIDTH;
   localparam int SW = DW / 8;
   localparam int LSB = $clog2(SW);
   localparam int IW = AW - LSB;

   logic          alive_q;
   logic          aw_held_q, w_held_q, bvalid_q, rvalid_q;
   logic [IW-1:0] awidx_q;
   logic [DW-1:0] wdata_q, rdata_q, rdata_d;
   logic [SW-1:0] wstrb_q;
   logic [1:0]    bresp_q, rresp_q;
   logic          aw_hs, w_hs, ar_hs, commit, wmapped, rmapped;
   logic [IW-1:0] widx, ridx;
   logic [DW-1:0] wdata_c;
   logic [SW-1:0] wstrb_c;
   logic          irq_en_q, irq_en_d, done_q, done_d, err_q, err_d;
   logic          start_q, start_d, irq_q, set_err, clr_done, clr_err;
   logic [DW-1:0] params_q [NUM_PARAMS];
   logic [DW-1:0] params_d [NUM_PARAMS];
   logic          unused_ok;

   // alive_q keeps every ready low until the first edge that samples rst high
   assign s00_axi.awready = alive_q && !aw_held_q && !bvalid_q;
   assign s00_axi.wready  = alive_q && !w_held_q && !bvalid_q;
   assign s00_axi.arready = alive_q && !rvalid_q;
   assign s00_axi.bvalid  = bvalid_q;
   assign s00_axi.bresp   = bresp_q;
   assign s00_axi.rvalid  = rvalid_q;
   assign s00_axi.rresp   = rresp_q;
   assign s00_axi.rdata   = rdata_q;
   assign start_o = start_q;
   assign irq_o   = irq_q;

   assign aw_hs = s00_axi.awvalid && s00_axi.awready;
   assign w_hs  = s00_axi.wvalid && s00_axi.wready;
   assign ar_hs = s00_axi.arvalid && s00_axi.arready;
   // a channel counts as present either from its holding register or from a handshake this cycle,
   // so bvalid rises one cycle after the later of the two handshakes
   assign commit  = (aw_held_q || aw_hs) && (w_held_q || w_hs);
   assign widx    = aw_held_q ? awidx_q : s00_axi.awaddr[AW-1:LSB];
   assign wdata_c = w_held_q ? wdata_q : s00_axi.wdata;
   assign wstrb_c = w_held_q ? wstrb_q : s00_axi.wstrb;
   assign ridx    = s00_axi.araddr[AW-1:LSB];
   assign wmapped = int'(widx) < NUM_PARAMS + REG_PARAM0;
   assign rmapped = int'(ridx) < NUM_PARAMS + REG_PARAM0;
   assign unused_ok = ^{s00_axi.awprot, s00_axi.arprot, s00_axi.awaddr[LSB-1:0], s00_axi.araddr[LSB-1:0]};

   for (genvar g = 0; g < NUM_PARAMS; g++) begin : g_params
      assign params_o[g*DW +: DW] = params_q[g];
   end

   always_ff @(posedge clk) begin : write_path
      if (!rst) begin
         alive_q   <= 1'b0;
         aw_held_q <= 1'b0;
         w_held_q  <= 1'b0;
         awidx_q   <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
      end else begin
         alive_q   <= 1'b1;
         aw_held_q <= !commit && (aw_held_q || aw_hs);
         w_held_q  <= !commit && (w_held_q || w_hs);
         if (aw_hs) awidx_q <= s00_axi.awaddr[AW-1:LSB];
         if (w_hs) begin
            wdata_q <= s00_axi.wdata;
            wstrb_q <= s00_axi.wstrb;
         end
         if (commit) begin
            bvalid_q <= 1'b1;
            bresp_q  <= wmapped ? RESP_OKAY : RESP_SLVERR;
         end else if (s00_axi.bready) begin
            bvalid_q <= 1'b0;
         end
      end
   end

   always_comb begin
      rdata_d = '0;
      if (int'(ridx) == REG_CTRL) begin
         rdata_d[CTRL_IRQ_EN] = irq_en_q;
      end else if (int'(ridx) == REG_STATUS) begin
         rdata_d[ST_READY]     = core_ready_i;
         rdata_d[ST_DONE]      = done_q;
         rdata_d[ST_START_ERR] = err_q;
      end
      for (int i = 0; i < NUM_PARAMS; i++)
         if (int'(ridx) == REG_PARAM0 + i) rdata_d = params_q[i];
   end

   always_ff @(posedge clk) begin : read_path
      if (!rst) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         rresp_q  <= RESP_OKAY;
      end else if (ar_hs) begin
         rvalid_q <= 1'b1;
         rdata_q  <= rdata_d;
         rresp_q  <= rmapped ? RESP_OKAY : RESP_SLVERR;
      end else if (s00_axi.rready) begin
         rvalid_q <= 1'b0;
      end
   end

   // CTRL/STATUS bits all live in byte lane 0, so that lane gates them
   always_comb begin
      irq_en_d = irq_en_q;
      params_d = params_q;
      start_d  = 1'b0;
      set_err  = 1'b0;
      clr_done = 1'b0;
      clr_err  = 1'b0;
      if (commit && wstrb_c[0] && int'(widx) == REG_CTRL) begin
         irq_en_d = wdata_c[CTRL_IRQ_EN];
         start_d  = wdata_c[CTRL_START] && core_ready_i;
         set_err  = wdata_c[CTRL_START] && !core_ready_i;
      end
      if (commit && wstrb_c[0] && int'(widx) == REG_STATUS) begin
         clr_done = wdata_c[ST_DONE];
         clr_err  = wdata_c[ST_START_ERR];
      end
      for (int i = 0; i < NUM_PARAMS; i++)
         for (int b = 0; b < SW; b++)
            if (commit && wstrb_c[b] && int'(widx) == REG_PARAM0 + i) params_d[i][b*8 +: 8] = wdata_c[b*8 +: 8];
      // a set event in the same cycle as its W1C wins
      done_d = core_done_i || (done_q && !clr_done);
      err_d  = set_err || (err_q && !clr_err);
   end

   always_ff @(posedge clk) begin : reg_bank
      if (!rst) begin
         irq_en_q <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         start_q  <= 1'b0;
         irq_q    <= 1'b0;
         for (int i = 0; i < NUM_PARAMS; i++) params_q[i] <= '0;
      end else begin
         irq_en_q <= irq_en_d;
         done_q   <= done_d;
         err_q    <= err_d;
         start_q  <= start_d;
         irq_q    <= done_q && irq_en_q;
         params_q <= params_d;
      end
   end
endmodule

// File: tb/tb_surf_axil_ctrl.sv
// tb_surf_axil_ctrl: directed self-checking bench for surf_axil_ctrl
module tb_surf_axil_ctrl;
   logic         clk;
   logic         rst;
   logic         core_ready_i;
   logic         core_done_i;
   logic         start_o;
   logic [255:0] params_o;
   logic         irq_o;
   logic [255:0] exp_p;
   logic [1:0]   resp;
   logic         st_at_b;
   int           vectors;
   int           miscompares;
   int           start_cnt;
   int           c0;

   surf_axil_ctrl_if #(.DW(32), .AW(7)) bus ();

   surf_axil_ctrl #(
      .C_S00_AXI_DATA_WIDTH(32),
      .C_S00_AXI_ADDR_WIDTH(7),
      .NUM_PARAMS(8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .s00_axi(bus),
      .core_ready_i(core_ready_i),
      .core_done_i(core_done_i),
      .start_o(start_o),
      .params_o(params_o),
      .irq_o(irq_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (start_o === 1'b1) start_cnt++;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wr(input logic [6:0] a, input logic [31:0] d, input logic [3:0] s, output logic [1:0] r);
      bit aw_ok, w_ok;
      int n;
      aw_ok = 0;
      w_ok = 0;
      n = 0;
      bus.awaddr = a;
      bus.wdata = d;
      bus.wstrb = s;
      bus.awvalid = 1'b1;
      bus.wvalid = 1'b1;
      bus.bready = 1'b1;
      while (!(aw_ok && w_ok) && n < 20) begin
         if (bus.awvalid && bus.awready) aw_ok = 1;
         if (bus.wvalid && bus.wready) w_ok = 1;
         step();
         if (aw_ok) bus.awvalid = 1'b0;
         if (w_ok) bus.wvalid = 1'b0;
         n++;
      end
      bus.awvalid = 1'b0;
      bus.wvalid = 1'b0;
      chk("wr_bvalid", bus.bvalid, 1);
      r = bus.bresp;
      st_at_b = start_o;
      step();
   endtask

   task automatic rd(input string tag, input logic [6:0] a, input int hold, input logic [31:0] ed, input logic [1:0] er);
      bit ok;
      int n;
      ok = 0;
      n = 0;
      bus.araddr = a;
      bus.arvalid = 1'b1;
      bus.rready = 1'b0;
      while (!ok && n < 20) begin
         ok = bus.arvalid && bus.arready;
         step();
         n++;
      end
      bus.arvalid = 1'b0;
      chk({tag, "_rvalid"}, bus.rvalid, 1);
      chk({tag, "_rdata"}, bus.rdata, ed);
      chk({tag, "_rresp"}, bus.rresp, er);
      for (int i = 0; i < hold; i++) begin
         step();
         chk({tag, "_hold_rvalid"}, bus.rvalid, 1);
         chk({tag, "_hold_rdata"}, bus.rdata, ed);
      end
      bus.rready = 1'b1;
      step();
      bus.rready = 1'b0;
      chk({tag, "_rvalid_drop"}, bus.rvalid, 0);
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      start_cnt = 0;
      rst = 1'b0;
      core_ready_i = 1'b0;
      core_done_i = 1'b0;
      bus.awaddr = '0;
      bus.awprot = '0;
      bus.awvalid = 1'b0;
      bus.wdata = '0;
      bus.wstrb = '0;
      bus.wvalid = 1'b0;
      bus.bready = 1'b0;
      bus.araddr = '0;
      bus.arprot = '0;
      bus.arvalid = 1'b0;
      bus.rready = 1'b0;
      exp_p = '0;
      step();
      step();
      chk("rst_awready", bus.awready, 0);
      chk("rst_wready", bus.wready, 0);
      chk("rst_arready", bus.arready, 0);
      chk("rst_bvalid", bus.bvalid, 0);
      chk("rst_rvalid", bus.rvalid, 0);
      chk("rst_rdata", bus.rdata, 0);
      chk("rst_start", start_o, 0);
      chk("rst_irq", irq_o, 0);
      chk("rst_params", params_o, 0);
      rst = 1'b1;
      step();
      chk("alive_awready", bus.awready, 1);
      chk("alive_arready", bus.arready, 1);
      // AW at cycle 0, W at cycle 3
      bus.awaddr = 7'd8;
      bus.awvalid = 1'b1;
      bus.bready = 1'b1;
      step();
      bus.awvalid = 1'b0;
      chk("aw_held_awready", bus.awready, 0);
      step();
      step();
      chk("c3_bvalid", bus.bvalid, 0);
      chk("c3_wready", bus.wready, 1);
      bus.wdata = 32'hDEADBEEF;
      bus.wstrb = 4'hF;
      bus.wvalid = 1'b1;
      step();
      bus.wvalid = 1'b0;
      chk("c4_bvalid", bus.bvalid, 1);
      chk("c4_bresp", bus.bresp, 2'b00);
      exp_p[31:0] = 32'hDEADBEEF;
      chk("c4_param0", params_o, exp_p);
      step();
      chk("c5_bvalid", bus.bvalid, 0);
      // byte-lane write to PARAM[1]
      wr(7'd12, 32'h12345678, 4'hF, resp);
      exp_p[63:32] = 32'h12345678;
      chk("p1_full", params_o, exp_p);
      wr(7'd12, 32'h0000FFFF, 4'b0011, resp);
      exp_p[63:32] = 32'h1234FFFF;
      chk("p1_strb", params_o, exp_p);
      rd("p1_rd", 7'd12, 3, 32'h1234FFFF, 2'b00);
      // start with core ready, done, irq
      core_ready_i = 1'b1;
      c0 = start_cnt;
      wr(7'd0, 32'h3, 4'hF, resp);
      chk("ctrl_bresp", resp, 2'b00);
      chk("start_at_b", st_at_b, 1);
      step();
      step();
      step();
      chk("start_once", start_cnt - c0, 1);
      chk("irq_before_done", irq_o, 0);
      core_done_i = 1'b1;
      step();
      core_done_i = 1'b0;
      step();
      chk("irq_set", irq_o, 1);
      rd("st_done", 7'd4, 0, 32'h3, 2'b00);
      wr(7'd4, 32'h2, 4'hF, resp);
      chk("irq_clr", irq_o, 0);
      rd("st_clr", 7'd4, 0, 32'h1, 2'b00);
      // start while core busy
      core_ready_i = 1'b0;
      c0 = start_cnt;
      wr(7'd0, 32'h1, 4'hF, resp);
      step();
      step();
      chk("no_start", start_cnt - c0, 0);
      rd("st_err", 7'd4, 0, 32'h4, 2'b00);
      wr(7'd4, 32'h4, 4'b0000, resp);
      rd("st_err_nostrb", 7'd4, 0, 32'h4, 2'b00);
      wr(7'd4, 32'h4, 4'hF, resp);
      rd("st_err_clr", 7'd4, 0, 32'h0, 2'b00);
      wr(7'd0, 32'h2, 4'hF, resp);
      rd("ctrl_irqen", 7'd0, 0, 32'h2, 2'b00);
      // done set in the same cycle as its W1C
      core_done_i = 1'b1;
      step();
      core_done_i = 1'b0;
      bus.awaddr = 7'd4;
      bus.wdata = 32'h2;
      bus.wstrb = 4'hF;
      bus.awvalid = 1'b1;
      bus.wvalid = 1'b1;
      bus.bready = 1'b1;
      core_done_i = 1'b1;
      step();
      bus.awvalid = 1'b0;
      bus.wvalid = 1'b0;
      core_done_i = 1'b0;
      chk("race_bvalid", bus.bvalid, 1);
      step();
      rd("race_done", 7'd4, 0, 32'h2, 2'b00);
      chk("race_irq", irq_o, 1);
      // unmapped and boundary indices
      wr(7'd40, 32'hFFFFFFFF, 4'hF, resp);
      chk("unmap_bresp", resp, 2'b10);
      chk("unmap_params", params_o, exp_p);
      rd("unmap10", 7'd40, 0, 32'h0, 2'b10);
      rd("unmap15", 7'd60, 0, 32'h0, 2'b10);
      rd("unmap_ctrl", 7'd0, 0, 32'h2, 2'b00);
      wr(7'd36, 32'hCAFEF00D, 4'hF, resp);
      chk("p7_bresp", resp, 2'b00);
      exp_p[255:224] = 32'hCAFEF00D;
      chk("p7_params", params_o, exp_p);
      rd("p7_rd", 7'd36, 0, 32'hCAFEF00D, 2'b00);
      // reset while B is pending
      bus.awaddr = 7'd8;
      bus.wdata = 32'h1;
      bus.wstrb = 4'hF;
      bus.awvalid = 1'b1;
      bus.wvalid = 1'b1;
      bus.bready = 1'b0;
      step();
      bus.awvalid = 1'b0;
      bus.wvalid = 1'b0;
      chk("pend_bvalid", bus.bvalid, 1);
      rst = 1'b0;
      step();
      chk("mid_rst_bvalid", bus.bvalid, 0);
      chk("mid_rst_awready", bus.awready, 0);
      chk("mid_rst_params", params_o, 0);
      chk("mid_rst_irq", irq_o, 0);
      rst = 1'b1;
      bus.bready = 1'b1;
      step();
      chk("post_rst_awready", bus.awready, 1);
      chk("post_rst_bvalid", bus.bvalid, 0);
      rd("post_rst_ctrl", 7'd0, 0, 32'h0, 2'b00);
      rd("post_rst_status", 7'd4, 0, 32'h0, 2'b00);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
